// File: rtl/miim_phy_link_mgr.sv
// MIIM sequencer: BMCR init write, periodic PHY status poll, host access.
// Optional sticky status interrupt when MIIM_STATUS_IRQ_EN is defined.
module miim_phy_link_mgr #(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [4:0]  STAT_REGAD  = 5'h11,
  parameter logic [15:0] INIT_BMCR   = 16'h1140,
  parameter int          POLL_CYC    = 5000000,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [4:0]  host_phyad,
  input  logic [4:0]  host_regad,
  input  logic [15:0] host_wrdata,
  output logic        host_ack,
  output logic [15:0] host_rddata,
  output logic        host_err,
  output logic [4:0]  miim_phyad,
  output logic [4:0]  miim_regad,
  output logic [15:0] miim_wrdata,
  output logic        miim_wren,
  output logic        miim_rden,
  input  logic [15:0] miim_rddata,
  input  logic        miim_rddata_valid,
  input  logic        miim_busy,
  output logic        link_up,
  output logic        speedis1000,
  output logic        speedis10,
  output logic        duplex_status,
  output logic        status_chg
`ifdef MIIM_STATUS_IRQ_EN
  ,
  output logic        status_irq,
  input  logic        status_irq_clr
`endif
);

  localparam int PW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OWN_INIT, OWN_HOST, OWN_POLL
  } own_e;

  state_e        state_q, state_d;
  own_e          own_q, own_d;
  logic          wr_q, wr_d;
  logic          arm_q, arm_d;
  logic [4:0]    phyad_q, phyad_d;
  logic [4:0]    regad_q, regad_d;
  logic [15:0]   wrdata_q, wrdata_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          seen_q, seen_d;
  logic          to_q, to_d;
  logic [15:0]   rd_q, rd_d;
  logic [15:0]   hrd_q, hrd_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          pend_q, pend_d;
  logic          last_host_q, last_host_d;
  logic          link_q, link_d;
  logic          s1000_q, s1000_d;
  logic          s10_q, s10_d;
  logic          dup_q, dup_d;
  logic          chg_q, chg_d;

  logic issue_go;
  logic done_w;
  logic tmo_w;
  logic s1000_n;
  logic s10_n;
  logic dup_n;

  // A strobe only fires in a cycle where the MAC engine is idle
  assign issue_go = !miim_busy &&
                    ((state_q == S_ISSUE) ||
                     ((state_q == S_INIT) && arm_q));

  assign miim_wren     = issue_go && wr_q;
  assign miim_rden     = issue_go && !wr_q;
  assign miim_phyad    = phyad_q;
  assign miim_regad    = regad_q;
  assign miim_wrdata   = wrdata_q;
  assign host_ack      = (state_q == S_DONE) && (own_q == OWN_HOST);
  assign host_err      = host_ack && to_q;
  assign host_rddata   = hrd_q;
  assign link_up       = link_q;
  assign speedis1000   = s1000_q;
  assign speedis10     = s10_q;
  assign duplex_status = dup_q;
  assign status_chg    = chg_q;

  // Next-state: sequencing, arbitration, completion and poll decode
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    wr_d        = wr_q;
    arm_d       = arm_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    wrdata_d    = wrdata_q;
    tmo_d       = tmo_q;
    seen_d      = seen_q;
    to_d        = to_q;
    rd_d        = rd_q;
    hrd_d       = hrd_q;
    pend_d      = pend_q;
    last_host_d = last_host_q;
    link_d      = link_q;
    s1000_d     = s1000_q;
    s10_d       = s10_q;
    dup_d       = dup_q;
    chg_d       = 1'b0;
    done_w      = 1'b0;
    tmo_w       = 1'b0;
    s1000_n     = s1000_q;
    s10_n       = s10_q;
    dup_n       = dup_q;

    unique case (state_q)
      S_INIT: begin
        if (!arm_q) begin
          phyad_d  = PHY_ADDR;
          regad_d  = 5'd0;
          wrdata_d = INIT_BMCR;
          wr_d     = 1'b1;
          own_d    = OWN_INIT;
          arm_d    = 1'b1;
        end else if (!miim_busy) begin
          arm_d   = 1'b0;
          tmo_d   = '0;
          seen_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_IDLE: begin
        if (host_req && (!pend_q || !last_host_q)) begin
          own_d       = OWN_HOST;
          wr_d        = host_wr;
          phyad_d     = host_phyad;
          regad_d     = host_regad;
          wrdata_d    = host_wrdata;
          last_host_d = 1'b1;
          state_d     = S_ISSUE;
        end else if (pend_q) begin
          own_d       = OWN_POLL;
          wr_d        = 1'b0;
          phyad_d     = PHY_ADDR;
          regad_d     = STAT_REGAD;
          wrdata_d    = 16'h0000;
          last_host_d = 1'b0;
          pend_d      = 1'b0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!miim_busy) begin
          tmo_d   = '0;
          seen_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wr_q && miim_rddata_valid) begin
          done_w = 1'b1;
          rd_d   = miim_rddata;
        end else if (wr_q && seen_q && !miim_busy) begin
          done_w = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          done_w = 1'b1;
          tmo_w  = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
        if (wr_q && miim_busy) begin
          seen_d = 1'b1;
        end
        if (done_w) begin
          to_d    = tmo_w;
          state_d = S_DONE;
          if (own_q == OWN_HOST) begin
            if (tmo_w) begin
              hrd_d = 16'hFFFF;
            end else if (!wr_q) begin
              hrd_d = miim_rddata;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if ((own_q == OWN_POLL) && !to_q) begin
          if (rd_q[10]) begin
            unique case (rd_q[15:14])
              2'b10: begin
                s1000_n = 1'b1;
                s10_n   = 1'b0;
              end
              2'b01: begin
                s1000_n = 1'b0;
                s10_n   = 1'b0;
              end
              2'b00: begin
                s1000_n = 1'b0;
                s10_n   = 1'b1;
              end
              2'b11: begin
                s1000_n = s1000_q;
                s10_n   = s10_q;
              end
            endcase
            dup_n = rd_q[13];
          end
          link_d  = rd_q[10];
          s1000_d = s1000_n;
          s10_d   = s10_n;
          dup_d   = dup_n;
          chg_d   = (rd_q[10] != link_q) ||
                    (s1000_n != s1000_q) ||
                    (s10_n != s10_q) ||
                    (dup_n != dup_q);
        end
      end
      default: state_d = S_INIT;
    endcase

    if (pcnt_q == POLL_LAST) begin
      pcnt_d = '0;
      pend_d = 1'b1;
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_INIT;
      own_q       <= OWN_INIT;
      wr_q        <= 1'b0;
      arm_q       <= 1'b0;
      phyad_q     <= 5'd0;
      regad_q     <= 5'd0;
      wrdata_q    <= 16'h0000;
      tmo_q       <= '0;
      seen_q      <= 1'b0;
      to_q        <= 1'b0;
      rd_q        <= 16'h0000;
      hrd_q       <= 16'h0000;
      pcnt_q      <= '0;
      pend_q      <= 1'b0;
      last_host_q <= 1'b0;
      link_q      <= 1'b0;
      s1000_q     <= 1'b0;
      s10_q       <= 1'b0;
      dup_q       <= 1'b1;
      chg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      wr_q        <= wr_d;
      arm_q       <= arm_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      wrdata_q    <= wrdata_d;
      tmo_q       <= tmo_d;
      seen_q      <= seen_d;
      to_q        <= to_d;
      rd_q        <= rd_d;
      hrd_q       <= hrd_d;
      pcnt_q      <= pcnt_d;
      pend_q      <= pend_d;
      last_host_q <= last_host_d;
      link_q      <= link_d;
      s1000_q     <= s1000_d;
      s10_q       <= s10_d;
      dup_q       <= dup_d;
      chg_q       <= chg_d;
    end
  end

`ifdef MIIM_STATUS_IRQ_EN
  logic irq_q, irq_d;

  // Sticky flag: a status change outranks a clear in the same cycle
  always_comb begin
    irq_d = chg_q | (irq_q & ~status_irq_clr);
  end

  // Interrupt flag register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign status_irq = irq_q;
`endif

endmodule

// File: tb/tb_miim_phy_link_mgr.sv
// Bench for miim_phy_link_mgr: MAC/PHY model plus link-state reference.
// Random status words and host reads, directed arbitration and timeouts.
module tb_miim_phy_link_mgr;

  localparam logic [4:0] PA = 5'd1;
  localparam logic [4:0] SR = 5'h11;

  logic        clk;
  logic        rstn;
  logic        host_req;
  logic        host_wr;
  logic [4:0]  host_phyad;
  logic [4:0]  host_regad;
  logic [15:0] host_wrdata;
  logic        host_ack;
  logic [15:0] host_rddata;
  logic        host_err;
  logic [4:0]  miim_phyad;
  logic [4:0]  miim_regad;
  logic [15:0] miim_wrdata;
  logic        miim_wren;
  logic        miim_rden;
  logic [15:0] miim_rddata;
  logic        miim_rddata_valid;
  logic        miim_busy;
  logic        link_up;
  logic        speedis1000;
  logic        speedis10;
  logic        duplex_status;
  logic        status_chg;
`ifdef MIIM_STATUS_IRQ_EN
  logic        status_irq;
  logic        status_irq_clr;
`endif

  miim_phy_link_mgr #(
    .PHY_ADDR(PA),
    .STAT_REGAD(SR),
    .INIT_BMCR(16'h1140),
    .POLL_CYC(100),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .host_req(host_req),
    .host_wr(host_wr),
    .host_phyad(host_phyad),
    .host_regad(host_regad),
    .host_wrdata(host_wrdata),
    .host_ack(host_ack),
    .host_rddata(host_rddata),
    .host_err(host_err),
    .miim_phyad(miim_phyad),
    .miim_regad(miim_regad),
    .miim_wrdata(miim_wrdata),
    .miim_wren(miim_wren),
    .miim_rden(miim_rden),
    .miim_rddata(miim_rddata),
    .miim_rddata_valid(miim_rddata_valid),
    .miim_busy(miim_busy),
    .link_up(link_up),
    .speedis1000(speedis1000),
    .speedis10(speedis10),
    .duplex_status(duplex_status),
    .status_chg(status_chg)
`ifdef MIIM_STATUS_IRQ_EN
    ,
    .status_irq(status_irq),
    .status_irq_clr(status_irq_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC/PHY model state
  logic [15:0] phy_mem [32];
  logic [15:0] stat_val;
  logic        hold_busy;
  logic        drop_valid;
  int          busy_left;
  logic        rd_op;
  logic        rsp_is_stat;
  logic [4:0]  cap_phyad;
  logic [4:0]  cap_regad;
  logic [15:0] cap_wrdata;
  logic [4:0]  w_regad;
  logic [4:0]  w_phyad;
  logic [15:0] w_wrdata;
  int          wr_cnt;
  int          ack_cnt;
  int          cyc;
  int          strobe_cyc;
  int          strobe_viol;
  int          stab_viol;
  logic [4:0]  rd_log [$];

  assign miim_busy = (busy_left != 0) || hold_busy;

  // MAC management engine: busy after each strobe, read data at the end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (host_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    miim_rddata_valid <= 1'b0;
    rsp_is_stat <= 1'b0;
    if (!rstn) begin
      busy_left <= 0;
    end else if ((miim_wren === 1'b1) || (miim_rden === 1'b1)) begin
      if (miim_busy) strobe_viol <= strobe_viol + 1;
      if ((miim_wren === 1'b1) && (miim_rden === 1'b1))
        strobe_viol <= strobe_viol + 1;
      cap_phyad  <= miim_phyad;
      cap_regad  <= miim_regad;
      cap_wrdata <= miim_wrdata;
      if (miim_wren === 1'b1) begin
        wr_cnt    <= wr_cnt + 1;
        w_phyad   <= miim_phyad;
        w_regad   <= miim_regad;
        w_wrdata  <= miim_wrdata;
        busy_left <= 3;
        rd_op     <= 1'b0;
      end else begin
        busy_left  <= int'($urandom_range(1, 4));
        rd_op      <= 1'b1;
        strobe_cyc <= cyc;
        rd_log.push_back(miim_regad);
      end
    end else if (busy_left > 0) begin
      if (miim_regad != cap_regad || miim_phyad != cap_phyad ||
          miim_wrdata != cap_wrdata)
        stab_viol <= stab_viol + 1;
      busy_left <= busy_left - 1;
      if (busy_left == 1 && rd_op) begin
        if (cap_regad == SR && cap_phyad == PA) begin
          miim_rddata_valid <= 1'b1;
          rsp_is_stat <= 1'b1;
          miim_rddata <= stat_val;
        end else if (!drop_valid) begin
          miim_rddata_valid <= 1'b1;
          miim_rddata <= phy_mem[cap_regad];
        end
      end
    end
  end

  int n_cmp;
  int n_err;

  // Reference link state: speed in Mb/s, duplex, link
  int m_spd;
  bit m_dup;
  bit m_link;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ack"}, 32'(host_ack), 32'd0);
    chk({tag, "_rd"}, 32'(host_rddata), 32'd0);
    chk({tag, "_err"}, 32'(host_err), 32'd0);
    chk({tag, "_pa"}, 32'(miim_phyad), 32'd0);
    chk({tag, "_ra"}, 32'(miim_regad), 32'd0);
    chk({tag, "_wd"}, 32'(miim_wrdata), 32'd0);
    chk({tag, "_stb"}, 32'({miim_wren, miim_rden}), 32'd0);
    chk({tag, "_link"}, 32'(link_up), 32'd0);
    chk({tag, "_spd"}, 32'({speedis1000, speedis10}), 32'd0);
    chk({tag, "_dup"}, 32'(duplex_status), 32'd1);
    chk({tag, "_chg"}, 32'(status_chg), 32'd0);
  endtask

  task automatic host_xfer(input logic wr, input logic [4:0] ra,
                           input logic [15:0] wd,
                           output logic [15:0] rd,
                           output logic err, output bit ok);
    @(negedge clk);
    host_req = 1'b1;
    host_wr = wr;
    host_phyad = PA;
    host_regad = ra;
    host_wrdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (host_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    rd = host_rddata;
    err = host_err;
    host_req = 1'b0;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (host_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_poll(input string tag, input bit clr);
    bit got;
    logic [15:0] rd;
    int ns;
    bit nd;
    bit nl;
    bit echg;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (miim_rddata_valid === 1'b1 && rsp_is_stat) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
    if (!got) return;
    rd = miim_rddata;
    nl = rd[10];
    ns = m_spd;
    nd = m_dup;
    if (rd[10]) begin
      case (rd[15:14])
        2'b10: ns = 1000;
        2'b01: ns = 100;
        2'b00: ns = 10;
        default: ns = m_spd;
      endcase
      nd = rd[13];
    end
    echg = (nl != m_link) || (ns != m_spd) || (nd != m_dup);
    m_link = nl;
    m_spd = ns;
    m_dup = nd;
    @(negedge clk);
    chk({tag, "_early"}, 32'(status_chg), 32'd0);
    @(negedge clk);
`ifdef MIIM_STATUS_IRQ_EN
    if (clr) status_irq_clr = 1'b1;
`else
    if (clr) chk({tag, "_noirq"}, 32'(status_chg), 32'(echg));
`endif
    chk({tag, "_link"}, 32'(link_up), 32'(m_link));
    chk({tag, "_1000"}, 32'(speedis1000), 32'(m_spd == 1000));
    chk({tag, "_10"}, 32'(speedis10), 32'(m_spd == 10));
    chk({tag, "_dup"}, 32'(duplex_status), 32'(m_dup));
    chk({tag, "_chg"}, 32'(status_chg), 32'(echg));
    @(negedge clk);
`ifdef MIIM_STATUS_IRQ_EN
    status_irq_clr = 1'b0;
`endif
    chk({tag, "_once"}, 32'(status_chg), 32'd0);
  endtask

  initial begin
    logic [15:0] rd;
    logic err;
    bit ok;
    int r;
    int t0;
    int a0;
    int w0;
    logic [15:0] wd;
    n_cmp = 0;
    n_err = 0;
    m_spd = 100;
    m_dup = 1'b1;
    m_link = 1'b0;
    cyc = 0;
    ack_cnt = 0;
    wr_cnt = 0;
    strobe_viol = 0;
    stab_viol = 0;
    strobe_cyc = 0;
    busy_left = 0;
    rd_op = 1'b0;
    hold_busy = 1'b0;
    drop_valid = 1'b0;
    stat_val = 16'hA400;
    miim_rddata = 16'h0000;
    miim_rddata_valid = 1'b0;
    rsp_is_stat = 1'b0;
    for (int i = 0; i < 32; i++) phy_mem[i] = 16'($urandom);
    host_req = 1'b0;
    host_wr = 1'b0;
    host_phyad = 5'd0;
    host_regad = 5'd0;
    host_wrdata = 16'h0000;
`ifdef MIIM_STATUS_IRQ_EN
    status_irq_clr = 1'b0;
`endif
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
`ifdef MIIM_STATUS_IRQ_EN
    chk("rst_irq", 32'(status_irq), 32'd0);
`endif
    rstn = 1'b1;

    for (int i = 0; i < 50 && wr_cnt == 0; i++) @(negedge clk);
    chk("init_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("init_pa", 32'(w_phyad), 32'(PA));
    chk("init_ra", 32'(w_regad), 32'd0);
    chk("init_wd", 32'(w_wrdata), 32'h1140);
    repeat (20) @(negedge clk);
    chk("init_once", 32'(wr_cnt), 32'd1);
    chk("init_noack", 32'(ack_cnt), 32'd0);

    wait_poll("p1000", 1'b0);
    wait_poll("psame", 1'b0);
    stat_val = 16'h0000;
    wait_poll("pdown", 1'b0);

`ifdef MIIM_STATUS_IRQ_EN
    status_irq_clr = 1'b1;
    @(negedge clk);
    status_irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_clr0", 32'(status_irq), 32'd0);
    stat_val = 16'hA400;
    wait_poll("irq_up", 1'b0);
    chk("irq_set", 32'(status_irq), 32'd1);
    stat_val = 16'h0000;
    wait_poll("irq_race", 1'b1);
    chk("irq_setwin", 32'(status_irq), 32'd1);
    status_irq_clr = 1'b1;
    @(negedge clk);
    status_irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_clr1", 32'(status_irq), 32'd0);
`endif

    for (int k = 0; k < 12; k++) begin
      r = int'($urandom_range(0, 31));
      if (r == int'(SR)) r = 2;
      host_xfer(1'b0, 5'(r), 16'h0, rd, err, ok);
      chk("hrd_ack", 32'(ok), 32'd1);
      chk("hrd_err", 32'(err), 32'd0);
      chk("hrd_data", 32'(rd), 32'(phy_mem[r]));
      stat_val = 16'($urandom);
      wait_poll("prand", 1'b0);
    end

    rd_log.delete();
    hold_busy = 1'b1;
    repeat (210) @(negedge clk);
    host_req = 1'b1;
    host_wr = 1'b0;
    host_phyad = PA;
    host_regad = 5'd2;
    repeat (5) @(negedge clk);
    hold_busy = 1'b0;
    wait_ack(ok);
    chk("arb1_ack", 32'(ok), 32'd1);
    chk("arb1_data", 32'(host_rddata), 32'(phy_mem[2]));
    host_req = 1'b0;
    for (int i = 0; i < 200 && rd_log.size() < 3; i++) @(negedge clk);
    chk("arb1_n", 32'(rd_log.size() >= 3), 32'd1);
    if (rd_log.size() >= 3) begin
      chk("arb1_o0", 32'(rd_log[0]), 32'(SR));
      chk("arb1_o1", 32'(rd_log[1]), 32'd2);
      chk("arb1_o2", 32'(rd_log[2]), 32'(SR));
    end

    rd_log.delete();
    host_req = 1'b1;
    host_regad = 5'd3;
    hold_busy = 1'b1;
    repeat (210) @(negedge clk);
    hold_busy = 1'b0;
    wait_ack(ok);
    chk("arb2_ack", 32'(ok), 32'd1);
    chk("arb2_data", 32'(host_rddata), 32'(phy_mem[3]));
    host_regad = 5'd4;
    wait_ack(ok);
    chk("arb2b_ack", 32'(ok), 32'd1);
    chk("arb2b_data", 32'(host_rddata), 32'(phy_mem[4]));
    host_req = 1'b0;
    chk("arb2_n", 32'(rd_log.size() >= 3), 32'd1);
    if (rd_log.size() >= 3) begin
      chk("arb2_o0", 32'(rd_log[0]), 32'd3);
      chk("arb2_o1", 32'(rd_log[1]), 32'(SR));
      chk("arb2_o2", 32'(rd_log[2]), 32'd4);
    end

    drop_valid = 1'b1;
    host_xfer(1'b0, 5'd5, 16'h0, rd, err, ok);
    t0 = cyc - strobe_cyc;
    drop_valid = 1'b0;
    chk("tmo_ack", 32'(ok), 32'd1);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_data", 32'(rd), 32'hFFFF);
    chk("tmo_lat", 32'(t0), 32'd65);
    host_xfer(1'b0, 5'd6, 16'h0, rd, err, ok);
    chk("post_ack", 32'(ok), 32'd1);
    chk("post_err", 32'(err), 32'd0);
    chk("post_data", 32'(rd), 32'(phy_mem[6]));

    wd = 16'($urandom);
    host_xfer(1'b1, 5'd9, wd, rd, err, ok);
    chk("hwr_ack", 32'(ok), 32'd1);
    chk("hwr_err", 32'(err), 32'd0);
    chk("hwr_hold", 32'(rd), 32'(phy_mem[6]));
    chk("hwr_ra", 32'(w_regad), 32'd9);
    chk("hwr_wd", 32'(w_wrdata), 32'(wd));

    @(negedge clk);
    host_req = 1'b1;
    host_wr = 1'b0;
    host_regad = 5'd7;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (miim_rden === 1'b1 && miim_regad == 5'd7) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_strobe", 32'(ok), 32'd1);
    rstn = 1'b0;
    host_req = 1'b0;
    a0 = ack_cnt;
    w0 = wr_cnt;
    repeat (2) @(negedge clk);
    chk_reset("mid");
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_noack", 32'(ack_cnt), 32'(a0));
    chk("mid_rewr", 32'(wr_cnt), 32'(w0 + 1));
    chk("mid_ra", 32'(w_regad), 32'd0);
    chk("mid_wd", 32'(w_wrdata), 32'h1140);

    chk("strobe_rule", 32'(strobe_viol), 32'd0);
    chk("addr_stable", 32'(stab_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
